// File: rtl/fuzzy_engine_arbiter.sv
// Round-robin arbiter that time-shares one fuzzy risk engine between N_SITES
// sensor sites: clamps and holds the winner's inputs, waits out the engine latency, captures risk.
module fuzzy_engine_arbiter #(
    parameter int N_SITES    = 4,
    parameter int ENGINE_LAT = 2,
    parameter int DATA_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SITES-1:0]          req,
    input  logic [N_SITES*DATA_W-1:0]   rain_bus,
    input  logic [N_SITES*DATA_W-1:0]   soil_bus,
    output logic [DATA_W-1:0]           eng_rain,
    output logic [DATA_W-1:0]           eng_soil,
    input  logic [DATA_W-1:0]           eng_risk,
    output logic [N_SITES-1:0]          gnt,
    output logic [N_SITES-1:0]          done,
    output logic [DATA_W-1:0]           risk_out,
    output logic                        clipped,
    output logic                        busy,
    output logic [15:0]                 eval_count
);

    localparam int SW = (N_SITES > 1) ? $clog2(N_SITES) : 1;
    localparam int CW = 4;
    localparam logic [DATA_W-1:0] CLAMP = DATA_W'(100);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       site_q, site_d;
    logic [SW-1:0]       last_q, last_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   rain_q, rain_d;
    logic [DATA_W-1:0]   soil_q, soil_d;
    logic                clip_pend_q, clip_pend_d;
    logic [N_SITES-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   risk_q, risk_d;
    logic                clipped_q, clipped_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                sel_found;
    logic [SW-1:0]       sel_idx;
    logic [DATA_W-1:0]   rain_sel, soil_sel;
    logic [N_SITES-1:0]  site_onehot;
    int                  idx;

    // Search starts one past the last served site so a steady requester waits at most N_SITES turns.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_SITES; k++) begin
            idx = (int'(last_q) + k) % N_SITES;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = SW'(idx);
            end
        end
    end

    assign rain_sel    = rain_bus[sel_idx*DATA_W +: DATA_W];
    assign soil_sel    = soil_bus[sel_idx*DATA_W +: DATA_W];
    assign site_onehot = N_SITES'(1) << site_q;

    always_comb begin
        state_d     = state_q;
        site_d      = site_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        rain_d      = rain_q;
        soil_d      = soil_q;
        clip_pend_d = clip_pend_q;
        done_d      = '0;
        risk_d      = risk_q;
        clipped_d   = clipped_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = ISSUE;
                    site_d      = sel_idx;
                    rain_d      = (rain_sel > CLAMP) ? CLAMP : rain_sel;
                    soil_d      = (soil_sel > CLAMP) ? CLAMP : soil_sel;
                    clip_pend_d = (rain_sel > CLAMP) || (soil_sel > CLAMP);
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wcnt_d  = CW'(ENGINE_LAT);
            end
            WAIT: begin
                if (wcnt_q == CW'(1)) state_d = CAPTURE;
                else                  wcnt_d  = wcnt_q - CW'(1);
            end
            CAPTURE: begin
                state_d   = IDLE;
                risk_d    = eng_risk;
                done_d    = site_onehot;
                clipped_d = clip_pend_q;
                cnt_d     = cnt_q + 16'd1;
                last_d    = site_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            site_q      <= '0;
            last_q      <= SW'(N_SITES - 1);
            wcnt_q      <= '0;
            rain_q      <= '0;
            soil_q      <= '0;
            clip_pend_q <= 1'b0;
            done_q      <= '0;
            risk_q      <= '0;
            clipped_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            site_q      <= site_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            rain_q      <= rain_d;
            soil_q      <= soil_d;
            clip_pend_q <= clip_pend_d;
            done_q      <= done_d;
            risk_q      <= risk_d;
            clipped_q   <= clipped_d;
            cnt_q       <= cnt_d;
        end
    end

    assign eng_rain   = rain_q;
    assign eng_soil   = soil_q;
    assign gnt        = (state_q == IDLE) ? '0 : site_onehot;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign risk_out   = risk_q;
    assign clipped    = clipped_q;
    assign eval_count = cnt_q;

endmodule

// File: tb/tb_fuzzy_engine_arbiter.sv
// Scoreboard bench for fuzzy_engine_arbiter: a behavioural engine drives eng_risk,
// expected completions are queued at request time and popped on every done pulse.
module tb_fuzzy_engine_arbiter;

    localparam int N = 4;
    localparam int L = 2;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] rain_bus, soil_bus;
    logic [W-1:0]   eng_rain, eng_soil, eng_risk, risk_out;
    logic [N-1:0]   gnt, done;
    logic           clipped, busy;
    logic [15:0]    eval_count;

    typedef struct {
        int         site;
        logic [W-1:0] risk;
        logic       clip;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;

    fuzzy_engine_arbiter #(.N_SITES(N), .ENGINE_LAT(L), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .rain_bus(rain_bus), .soil_bus(soil_bus),
        .eng_rain(eng_rain), .eng_soil(eng_soil), .eng_risk(eng_risk),
        .gnt(gnt), .done(done), .risk_out(risk_out), .clipped(clipped),
        .busy(busy), .eval_count(eval_count)
    );

    always #5 clk = ~clk;

    // Behavioural fuzzy engine: any deterministic function of its inputs will do.
    assign eng_risk = (eng_rain + eng_soil) ^ 8'h53;

    function automatic logic [W-1:0] model(input logic [W-1:0] r, input logic [W-1:0] s);
        logic [W-1:0] rc, sc;
        rc = (r > 8'd100) ? 8'd100 : r;
        sc = (s > 8'd100) ? 8'd100 : s;
        return (rc + sc) ^ 8'h53;
    endfunction

    task automatic set_site(input int i, input logic [W-1:0] r, input logic [W-1:0] s);
        rain_bus[i*W +: W] = r;
        soil_bus[i*W +: W] = s;
    endtask

    task automatic push(input int site, input logic [W-1:0] r, input logic [W-1:0] s);
        exp_t e;
        e.site = site;
        e.risk = model(r, s);
        e.clip = (r > 8'd100) || (s > 8'd100);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && done !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done done=%b", done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                exp_count = exp_count + 16'd1;
                if (done !== (N'(1) << e.site) || risk_out !== e.risk ||
                    clipped !== e.clip || eval_count !== exp_count) begin
                    errors++;
                    $display("FAIL scoreboard got done=%b risk=%h clip=%b cnt=%0d want done=%b risk=%h clip=%b cnt=%0d",
                             done, risk_out, clipped, eval_count,
                             N'(1) << e.site, e.risk, e.clip, exp_count);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; req = '0; rain_bus = '0; soil_bus = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || risk_out !== '0 || eng_rain !== '0 ||
            eng_soil !== '0 || clipped !== 1'b0 || eval_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state gnt=%b done=%b busy=%b risk=%h rain=%h soil=%h clip=%b cnt=%0d want all 0",
                     gnt, done, busy, risk_out, eng_rain, eng_soil, clipped, eval_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_site(0, 8'd40, 8'd60);
        req = 4'b0001;
        push(0, 8'd40, 8'd60);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
            checks++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || eng_rain !== 8'd40 || eng_soil !== 8'd60) begin
                errors++;
                $display("FAIL single_grant c%0d gnt=%b busy=%b rain=%0d soil=%0d want 0001 1 40 60",
                         i, gnt, busy, eng_rain, eng_soil);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0001 || risk_out !== 8'h37 || eval_count !== 16'd1) begin
            errors++;
            $display("FAIL single_done done=%b risk=%h cnt=%0d want 0001 37 1", done, risk_out, eval_count);
        end
        @(negedge clk);
        checks++;
        if (done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        @(negedge clk); rst = 1'b1; exp_count = 16'd0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < N; i++) set_site(i, 8'(10 + 20*i), 8'(5 + 7*i));
        req = '1;
        for (int k = 0; k < 5; k++) push(k % N, 8'(10 + 20*(k % N)), 8'(5 + 7*(k % N)));
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 21) req = '0;
            want = (c % 5 == 0) ? (N'(1) << ((c/5 - 1) % N)) : '0;
            checks++;
            if (done !== want) begin
                errors++;
                $display("FAIL rr_done c%0d done=%b want %b", c, done, want);
            end
        end
    endtask

    task automatic test_clamp();
        @(negedge clk);
        set_site(1, 8'd200, 8'd50);
        req = 4'b0010;
        push(1, 8'd200, 8'd50);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
            checks++;
            if (gnt !== 4'b0010 || eng_rain !== 8'd100 || eng_soil !== 8'd50) begin
                errors++;
                $display("FAIL clamp_inputs c%0d gnt=%b rain=%0d soil=%0d want 0010 100 50", i, gnt, eng_rain, eng_soil);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0010 || clipped !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done done=%b clip=%b want 0010 1", done, clipped);
        end
        set_site(2, 8'd30, 8'd20);
        req = 4'b0100;
        push(2, 8'd30, 8'd20);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
            checks++;
            if (clipped !== 1'b1) begin
                errors++;
                $display("FAIL clip_hold c%0d clip=%b want 1", i, clipped);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0100 || clipped !== 1'b0) begin
            errors++;
            $display("FAIL clip_clear done=%b clip=%b want 0100 0", done, clipped);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        set_site(3, 8'd70, 8'd80);
        req = 4'b1000;
        push(3, 8'd70, 8'd80);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
            if (i == 2) set_site(3, 8'd250, 8'd0);
            checks++;
            if (gnt !== 4'b1000 || eng_rain !== 8'd70 || eng_soil !== 8'd80) begin
                errors++;
                $display("FAIL hold_inputs c%0d gnt=%b rain=%0d soil=%0d want 1000 70 80", i, gnt, eng_rain, eng_soil);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b1000 || risk_out !== model(8'd70, 8'd80)) begin
            errors++;
            $display("FAIL hold_done done=%b risk=%h want 1000 %h", done, risk_out, model(8'd70, 8'd80));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_site(0, 8'd10, 8'd10);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        #2 rst = 1'b1;
        #1;
        exp_count = 16'd0;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || done !== '0 || eng_rain !== '0 || eng_soil !== '0 ||
            risk_out !== '0 || clipped !== 1'b0 || eval_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset gnt=%b busy=%b done=%b rain=%h soil=%h risk=%h clip=%b cnt=%0d want all 0",
                     gnt, busy, done, eng_rain, eng_soil, risk_out, clipped, eval_count);
        end
        @(negedge clk);
        rst = 1'b0;
        push(2, 8'd30, 8'd20);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0100 || eval_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_done done=%b cnt=%0d want 0100 1", done, eval_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.cnt_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        set_site(1, 8'd5, 8'd6);
        req = 4'b0010;
        push(1, 8'd5, 8'd6);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0010 || eval_count !== 16'd0) begin
            errors++;
            $display("FAIL count_wrap done=%b cnt=%0d want 0010 0", done, eval_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_hold();
        test_reset_mid();
        test_wrap();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_done pending=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fuzzy_engine_arbiter.md
FUZZY_ENGINE_ARBITER -- requirements
Module: fuzzy_engine_arbiter

Interface
REQ-001 The block SHALL have parameter N_SITES, default 4, giving the number of sensor sites sharing one fuzzy risk engine (legal range 2..8).
REQ-002 The block SHALL have parameter ENGINE_LAT, default 2, giving the cycles from stable engine inputs to valid engine risk output (legal range 1..15).
REQ-003 The block SHALL have parameter DATA_W, default 8, giving the width of rainfall, soil moisture and risk values.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  N_SITES  per-site level request for one risk evaluation.
REQ-007 rain_bus  input  N_SITES*DATA_W  per-site rainfall; site i occupies bits [i*DATA_W +: DATA_W].
REQ-008 soil_bus  input  N_SITES*DATA_W  per-site soil moisture, same packing as rain_bus.
REQ-009 eng_rain  output  DATA_W  rainfall driven to the shared fuzzy engine.
REQ-010 eng_soil  output  DATA_W  soil moisture driven to the shared fuzzy engine.
REQ-011 eng_risk  input  DATA_W  risk returned by the shared fuzzy engine.
REQ-012 gnt  output  N_SITES  one-hot grant; identifies the site currently owning the engine.
REQ-013 done  output  N_SITES  one-hot, one-cycle completion pulse for the granted site.
REQ-014 risk_out  output  DATA_W  risk captured for the last completed evaluation.
REQ-015 clipped  output  1  set with done when either granted input exceeded 100 and was clamped.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 eval_count  output  16  count of completed evaluations.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, CAPTURE, encoded in registers.
REQ-019 IDLE: if req is nonzero, the block SHALL select one site by round-robin, starting the search at (last_site+1) mod N_SITES, and go to ISSUE; else stay in IDLE.
REQ-020 On the IDLE->ISSUE edge the block SHALL latch the selected site index and load eng_rain/eng_soil with that site's inputs, each clamped to min(value,100).
REQ-021 eng_rain and eng_soil SHALL hold constant from ISSUE through CAPTURE and retain their last value in IDLE.
REQ-022 gnt SHALL be one-hot for the latched site in ISSUE, WAIT and CAPTURE, and all-zero in IDLE.
REQ-023 ISSUE SHALL last exactly one cycle then go to WAIT with a wait counter loaded to ENGINE_LAT.
REQ-024 WAIT SHALL last exactly ENGINE_LAT cycles, then go to CAPTURE.
REQ-025 In CAPTURE (one cycle), risk_out SHALL register eng_risk, done[site] SHALL be 1 during the cycle after that edge, last_site SHALL update to site, and the FSM SHALL return to IDLE.
REQ-026 Latency: req sampled in IDLE at edge T SHALL yield done and valid risk_out in cycle T+ENGINE_LAT+3 (5 for default); back-to-back throughput SHALL be one evaluation per ENGINE_LAT+3 cycles.
REQ-027 Deasserting req after grant SHALL NOT abort the transaction; the evaluation SHALL complete and done SHALL still pulse.
REQ-028 Input changes on rain_bus/soil_bus after the IDLE->ISSUE edge SHALL NOT affect the transaction in progress.
REQ-029 clipped SHALL reflect the clamp of the transaction completing and hold until the next done.
REQ-030 eval_count SHALL increment by 1 per done and wrap from 65535 to 0.
REQ-031 Round-robin SHALL guarantee a continuously requesting site is served within N_SITES evaluations.

Reset
REQ-032 While rst is high the FSM SHALL be IDLE and gnt, done, risk_out, eng_rain, eng_soil, clipped, busy, eval_count SHALL be 0, and last_site SHALL be N_SITES-1 (so site 0 has first priority).
REQ-033 Reset asserted mid-transaction SHALL abort immediately with no done pulse; eval_count SHALL not increment.

Verification
REQ-034 Single request: req=0001, rain0=40, soil0=60, eng_risk model=0x37 -> gnt=0001 for 4 cycles, done=0001 at T+5, risk_out=0x37, eval_count=1.
REQ-035 All sites request continuously from reset -> grants in order 0,1,2,3,0, each done 5 cycles apart, no gaps or duplicates.
REQ-036 Clamp: rain1=200, soil1=50 -> eng_rain=100, eng_soil=50, clipped=1 with done=0010; next unclamped evaluation -> clipped=0.
REQ-037 req dropped one cycle after grant, rain changed during WAIT -> done still pulses, eng_rain unchanged.
REQ-038 rst pulsed during WAIT -> outputs 0 asynchronously, no done; after release pending req=0100 served first.
REQ-039 eval_count preset to 65535 via 65535 evaluations (or forced) -> next done wraps it to 0.
